// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII transmit path.
// Holds the transmit FSM state enum and the idle/error control codes.
package rgmii_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DDR_DATA = 2'd1,
        SDR_LO   = 2'd2,
        SDR_HI   = 2'd3
    } tx_state_e;

    // Control codes packed as {ctl_rise, ctl_fall}.
    localparam logic [1:0] CTL_IDLE = 2'b00;
    localparam logic [1:0] CTL_ERR  = 2'b10;

    // TX_EN on the rising edge, TX_EN ^ TX_ER on the falling edge.
    function automatic logic [1:0] ctl_data(input logic err);
        return {1'b1, ~err};
    endfunction

endpackage

// File: rtl/ddr_out_cell.sv
// One-bit DDR output: rise word while clk is high, fall word while low.
// Ports: clk, rst, d_rise/d_fall (word inputs), q (pin).
module ddr_out_cell (
    input  logic clk,
    input  logic rst,
    input  logic d_rise,
    input  logic d_fall,
    output logic q
);

`ifdef SYNTHESIS
    ODDR #(
        .DDR_CLK_EDGE("SAME_EDGE"),
        .INIT        (1'b0),
        .SRTYPE      ("SYNC")
    ) u_oddr (
        .Q (q),
        .C (clk),
        .CE(1'b1),
        .D1(d_rise),
        .D2(d_fall),
        .R (rst),
        .S (1'b0)
    );
`else
    logic rise_q;
    logic fall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= d_rise;
            fall_q <= d_fall;
        end
    end

    // Both halves are captured on the same edge, so the fall word
    // is stable for the whole low half-cycle.
    assign q = clk ? rise_q : fall_q;
`endif

endmodule

// File: rtl/rgmii_tx_ddr.sv
// RGMII transmit formatter: beat stream to DDR or SDR (10/100) words.
// Ports: clk, rst, mode, s_* beat input, d_*/ctl_* words, q_* pins, busy, underrun.
module rgmii_tx_ddr
    import rgmii_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mode,
    input  logic [2*DATA_WIDTH-1:0] s_data,
    input  logic                    s_valid,
    input  logic                    s_err,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic [DATA_WIDTH-1:0]   d_rise,
    output logic [DATA_WIDTH-1:0]   d_fall,
    output logic                    ctl_rise,
    output logic                    ctl_fall,
    output logic [DATA_WIDTH-1:0]   q_data,
    output logic                    q_ctl,
    output logic                    busy,
    output logic                    underrun
);

    tx_state_e state;
    tx_state_e state_n;
    logic      mode_q;
    logic      sdr;

    logic [DATA_WIDTH-1:0] lo;
    logic [DATA_WIDTH-1:0] hi;
    logic [DATA_WIDTH-1:0] hold_hi;
    logic                  hold_err;
    logic                  hold_last;

    logic [DATA_WIDTH-1:0] rise_n;
    logic [DATA_WIDTH-1:0] fall_n;
    logic [1:0]            ctl_n;
    logic                  under_n;

    assign lo      = s_data[DATA_WIDTH-1:0];
    assign hi      = s_data[2*DATA_WIDTH-1:DATA_WIDTH];
    assign s_ready = (state != SDR_HI);
    assign busy    = (state != IDLE);

    // Mode is only sampled in IDLE; mid-frame the latched copy rules.
    assign sdr = (state == IDLE) ? mode : mode_q;

    always_comb begin
        rise_n  = '0;
        fall_n  = '0;
        ctl_n   = CTL_IDLE;
        under_n = 1'b0;
        state_n = state;
        unique case (state)
            IDLE, DDR_DATA, SDR_LO: begin
                if (s_valid) begin
                    rise_n = lo;
                    fall_n = sdr ? lo : hi;
                    ctl_n  = ctl_data(s_err);
                    if (sdr)
                        state_n = SDR_HI;
                    else if (s_last)
                        state_n = IDLE;
                    else
                        state_n = DDR_DATA;
                end else if (state != IDLE) begin
                    ctl_n   = CTL_ERR;
                    under_n = 1'b1;
                    state_n = IDLE;
                end
            end
            SDR_HI: begin
                rise_n  = hold_hi;
                fall_n  = hold_hi;
                ctl_n   = ctl_data(hold_err);
                state_n = hold_last ? IDLE : SDR_LO;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            mode_q    <= 1'b0;
            hold_hi   <= '0;
            hold_err  <= 1'b0;
            hold_last <= 1'b0;
            d_rise    <= '0;
            d_fall    <= '0;
            ctl_rise  <= 1'b0;
            ctl_fall  <= 1'b0;
            underrun  <= 1'b0;
        end else begin
            state    <= state_n;
            d_rise   <= rise_n;
            d_fall   <= fall_n;
            ctl_rise <= ctl_n[1];
            ctl_fall <= ctl_n[0];
            underrun <= under_n;
            if (state == IDLE)
                mode_q <= mode;
            if (s_valid && s_ready && sdr) begin
                hold_hi   <= hi;
                hold_err  <= s_err;
                hold_last <= s_last;
            end
        end
    end

    for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_data
        ddr_out_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .d_rise(d_rise[i]),
            .d_fall(d_fall[i]),
            .q     (q_data[i])
        );
    end

    ddr_out_cell u_ctl (
        .clk   (clk),
        .rst   (rst),
        .d_rise(ctl_rise),
        .d_fall(ctl_fall),
        .q     (q_ctl)
    );

endmodule

// File: tb/tb_rgmii_tx_ddr.sv
// Directed bench for rgmii_tx_ddr (DATA_WIDTH = 4).
// Drives beats after each edge and checks outputs 1 ns past the next edge.
module tb_rgmii_tx_ddr;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_err;
    logic       s_last;
    logic       s_ready;
    logic [3:0] d_rise;
    logic [3:0] d_fall;
    logic       ctl_rise;
    logic       ctl_fall;
    logic [3:0] q_data;
    logic       q_ctl;
    logic       busy;
    logic       underrun;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rgmii_tx_ddr #(.DATA_WIDTH(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .mode    (mode),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_err   (s_err),
        .s_last  (s_last),
        .s_ready (s_ready),
        .d_rise  (d_rise),
        .d_fall  (d_fall),
        .ctl_rise(ctl_rise),
        .ctl_fall(ctl_fall),
        .q_data  (q_data),
        .q_ctl   (q_ctl),
        .busy    (busy),
        .underrun(underrun)
    );

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic [7:0] d,
                        input logic e, input logic l);
        s_valid = v;
        s_data  = d;
        s_err   = e;
        s_last  = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks {d_rise,d_fall}, {ctl_rise,ctl_fall}, busy, underrun.
    task automatic word(input string tag, input logic [7:0] d,
                        input logic [1:0] c, input logic b,
                        input logic u);
        check({tag, ".data"}, {d_rise, d_fall}, d);
        check({tag, ".ctl"}, {6'd0, ctl_rise, ctl_fall}, {6'd0, c});
        check({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
        check({tag, ".under"}, {7'd0, underrun}, {7'd0, u});
    endtask

    initial begin
        rst  = 1'b1;
        mode = 1'b0;
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        tick();
        word("reset", 8'h00, 2'b00, 1'b0, 1'b0);
        check("reset.ready", {7'd0, s_ready}, 8'd1);
        check("reset.q", {3'd0, q_data, q_ctl}, 8'h00);
        rst = 1'b0;

        // DDR frame 0x55, 0xD5(last)
        beat(1'b1, 8'h55, 1'b0, 1'b0);
        tick();
        word("ddr.b0", 8'h55, 2'b11, 1'b1, 1'b0);
        beat(1'b1, 8'hD5, 1'b0, 1'b1);
        tick();
        word("ddr.b1", 8'h5D, 2'b11, 1'b0, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        word("ddr.idle", 8'h00, 2'b00, 1'b0, 1'b0);
        check("ddr.q_hi", {3'd0, q_data, q_ctl}, {3'd0, 4'h5, 1'b1});
        @(negedge clk);
        #1;
        check("ddr.q_lo", {3'd0, q_data, q_ctl}, {3'd0, 4'hD, 1'b1});

        // SDR single beat 0xA3(last)
        mode = 1'b1;
        beat(1'b1, 8'hA3, 1'b0, 1'b1);
        tick();
        word("sdr.lo", 8'h33, 2'b11, 1'b1, 1'b0);
        check("sdr.ready_hi", {7'd0, s_ready}, 8'd0);
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        word("sdr.hi", 8'hAA, 2'b11, 1'b0, 1'b0);
        check("sdr.ready_end", {7'd0, s_ready}, 8'd1);
        tick();
        word("sdr.idle", 8'h00, 2'b00, 1'b0, 1'b0);

        // DDR underrun after beat 2 of 3
        mode = 1'b0;
        beat(1'b1, 8'h21, 1'b0, 1'b0);
        tick();
        word("ur.b0", 8'h12, 2'b11, 1'b1, 1'b0);
        beat(1'b1, 8'h43, 1'b0, 1'b0);
        tick();
        word("ur.b1", 8'h34, 2'b11, 1'b1, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        word("ur.err", 8'h00, 2'b10, 1'b0, 1'b1);
        tick();
        word("ur.after", 8'h00, 2'b00, 1'b0, 1'b0);

        // mode flips mid DDR frame; next frame is SDR
        beat(1'b1, 8'h34, 1'b0, 1'b0);
        tick();
        word("mc.b0", 8'h43, 2'b11, 1'b1, 1'b0);
        mode = 1'b1;
        beat(1'b1, 8'h78, 1'b0, 1'b1);
        tick();
        word("mc.b1", 8'h87, 2'b11, 1'b0, 1'b0);
        beat(1'b1, 8'h9C, 1'b0, 1'b1);
        tick();
        word("mc.sdr_lo", 8'hCC, 2'b11, 1'b1, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        word("mc.sdr_hi", 8'h99, 2'b11, 1'b0, 1'b0);

        // SDR two beats, error on second high half
        beat(1'b1, 8'h5E, 1'b0, 1'b0);
        tick();
        word("s2.lo0", 8'hEE, 2'b11, 1'b1, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        word("s2.hi0", 8'h55, 2'b11, 1'b1, 1'b0);
        beat(1'b1, 8'h6F, 1'b1, 1'b1);
        tick();
        word("s2.lo1", 8'hFF, 2'b10, 1'b1, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        word("s2.hi1", 8'h66, 2'b10, 1'b0, 1'b0);

        // reset while in SDR_HI
        beat(1'b1, 8'hB6, 1'b0, 1'b0);
        tick();
        word("rs.lo", 8'h66, 2'b11, 1'b1, 1'b0);
        rst = 1'b1;
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        word("rs.out", 8'h00, 2'b00, 1'b0, 1'b0);
        check("rs.ready", {7'd0, s_ready}, 8'd1);
        rst = 1'b0;

        // DDR single beat 0x12 with error, last (mode cleared by reset
        // is irrelevant here: mode input is 0 in IDLE)
        mode = 1'b0;
        beat(1'b1, 8'h12, 1'b1, 1'b1);
        tick();
        word("err", 8'h21, 2'b10, 1'b0, 1'b0);
        beat(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        word("err.idle", 8'h00, 2'b00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_ddr.md
RGMII_TX_DDR -- requirements
Module: rgmii_tx_ddr

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 4: output pin count; input beat width is 2*DATA_WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock; every register updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port mode  input  1  0 = DDR full-rate; 1 = SDR half-rate (10/100).
REQ-005 SHALL have port s_data  input  2*DATA_WIDTH  beat; low half goes out first.
REQ-006 SHALL have port s_valid  input  1  beat valid.
REQ-007 SHALL have port s_err  input  1  beat carries a transmit error.
REQ-008 SHALL have port s_last  input  1  final beat of frame.
REQ-009 SHALL have port s_ready  output  1  beat accepted when s_valid and s_ready are high on the same edge.
REQ-010 SHALL have port d_rise  output  DATA_WIDTH  registered rising-edge data word.
REQ-011 SHALL have port d_fall  output  DATA_WIDTH  registered falling-edge data word.
REQ-012 SHALL have ports ctl_rise and ctl_fall  output  1 each  registered control bits.
REQ-013 SHALL have ports q_data  output  DATA_WIDTH and q_ctl  output  1  DDR pins.
REQ-014 SHALL have port busy  output  1  high while a frame is in progress.
REQ-015 SHALL have port underrun  output  1  one-cycle pulse on mid-frame starvation.

Function
REQ-016 SHALL implement FSM states IDLE, DDR_DATA, SDR_LO, SDR_HI.
REQ-017 SHALL latch mode only in IDLE; a mode change mid-frame is ignored until the frame ends.
REQ-018 IDLE: s_ready=1. An accepted beat goes to DDR_DATA (mode=0) or SDR_HI (mode=1).
REQ-019 DDR_DATA: s_ready=1. Accepting a beat with s_last returns to IDLE.
REQ-020 SDR_HI: s_ready=0 for exactly one cycle. Goes to IDLE if the held beat had s_last, else to SDR_LO.
REQ-021 SDR_LO: s_ready=1. Accepting a beat goes to SDR_HI.
REQ-022 SHALL present accepted beat N on d_rise/d_fall one cycle after acceptance (latency 1).
REQ-023 DDR output: d_rise=s_data[DATA_WIDTH-1:0]; d_fall=s_data[2*DATA_WIDTH-1:DATA_WIDTH].
REQ-024 SDR output: the acceptance cycle puts the low half on both d_rise and d_fall; the SDR_HI cycle puts the held high half on both.
REQ-025 Data cycles: ctl_rise=1 and ctl_fall=1 XOR s_err of the beat.
REQ-026 Idle cycle (no beat emitted, no underrun): d_rise=d_fall=0 and ctl_rise=ctl_fall=0.
REQ-027 Underrun: s_valid=0 in DDR_DATA or SDR_LO.
- next cycle emits error code: data 0, ctl_rise=1, ctl_fall=0
- underrun pulses 1
- FSM returns to IDLE; the frame is aborted.
REQ-028 busy SHALL be 1 in DDR_DATA, SDR_LO and SDR_HI, else 0.
REQ-029 s_err on the last beat SHALL still emit normally and end the frame.
REQ-030 q_data and q_ctl SHALL carry the rise word during the clk-high half-cycle and the fall word during the low half, both registered from d_*/ctl_*.

Reset
REQ-031 rst SHALL force IDLE, and on the next edge set all registered outputs to 0. s_ready is 1 out of reset.
REQ-032 rst SHALL take priority over all events and abort any frame with no underrun pulse.
REQ-033 SHALL clear the latched mode to 0 (DDR) on rst.

Structure
REQ-034 Shared package rgmii_pkg SHALL hold the FSM state enum and the idle and error control-code constants.
REQ-035 Sub-module ddr_out_cell SHALL provide a one-bit DDR output, instantiated DATA_WIDTH+1 times. It has a vendor-primitive path under SYNTHESIS and a behavioural path otherwise.

Verification
REQ-036 DDR, DATA_WIDTH=4, frame 0x55,0xD5 (last): d_rise/d_fall = 5/5 then 5/D; ctl 1/1 twice; then idle 0/0.
REQ-037 SDR, single beat 0xA3 (last): d_rise=d_fall=3, then A; s_ready low during the A cycle; busy low afterward.
REQ-038 DDR 3-beat frame, s_valid dropped after beat 2: error code (data 0, ctl 1/0) one cycle; underrun=1 one cycle; state IDLE.
REQ-039 mode toggled 0->1 mid-DDR frame: frame finishes in DDR; next frame runs in SDR.
REQ-040 rst asserted in SDR_HI: next cycle all outputs 0, s_ready=1, underrun=0.
REQ-041 DDR beat 0x12 with s_err=1 (last): ctl_rise=1, ctl_fall=0, d_rise=2, d_fall=1.
